// File: rtl/stm_transition_scheduler_pkg.sv
// stm_sched_pkg: shared types and constants for the STM transition scheduler
//   transition_mode_t : how a pending segment change is released
//   sched_state_t     : scheduler FSM states
//   MODE_*            : named mode encodings, REP_INFINITE : repeat-forever count
package stm_sched_pkg;
  typedef enum logic [2:0] {
    TM_IMMEDIATE = 3'd0,
    TM_SYNC_IDX  = 3'd1,
    TM_SYS_TIME  = 3'd2,
    TM_GPIO      = 3'd3
  } transition_mode_t;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2
  } sched_state_t;
  localparam logic [2:0] MODE_IMMEDIATE = 3'd0;
  localparam logic [2:0] MODE_SYNC_IDX = 3'd1;
  localparam logic [2:0] MODE_SYS_TIME = 3'd2;
  localparam logic [2:0] MODE_GPIO = 3'd3;
  localparam logic [31:0] REP_INFINITE = 32'hFFFF_FFFF;
  function automatic logic mode_defined(input logic [2:0] m);
    return m <= MODE_GPIO;
  endfunction
endpackage

// File: rtl/stm_transition_scheduler_if.sv
// stm_transition_scheduler_if: controller/swapchain-side signals of one STM scheduler
//   request : SETTINGS_VALID, REQ_SEGMENT, REQ_REP, TRANSITION_MODE, TRANSITION_VALUE
//   status  : SYS_TIME, GPIO_IN, CUR_SEGMENT, IDX_0/1, CYCLE_0/1
//   result  : UPDATE_SETTINGS, REQ_RD_SEGMENT, REP_0/1, PENDING, DROPPED, MODE_ERR
//   master drives request/status, slave (the scheduler) drives result
interface stm_transition_scheduler_if #(
  parameter int TIME_W = 64,
  parameter int GPIO_N = 4
);
  logic SETTINGS_VALID;
  logic REQ_SEGMENT;
  logic [31:0] REQ_REP;
  logic [2:0] TRANSITION_MODE;
  logic [TIME_W-1:0] TRANSITION_VALUE;
  logic [TIME_W-1:0] SYS_TIME;
  logic [GPIO_N-1:0] GPIO_IN;
  logic CUR_SEGMENT;
  logic [15:0] IDX_0;
  logic [15:0] IDX_1;
  logic [15:0] CYCLE_0;
  logic [15:0] CYCLE_1;
  logic UPDATE_SETTINGS;
  logic REQ_RD_SEGMENT;
  logic [31:0] REP_0;
  logic [31:0] REP_1;
  logic PENDING;
  logic DROPPED;
  logic MODE_ERR;
  modport master (
    output SETTINGS_VALID, REQ_SEGMENT, REQ_REP, TRANSITION_MODE, TRANSITION_VALUE,
    output SYS_TIME, GPIO_IN, CUR_SEGMENT, IDX_0, IDX_1, CYCLE_0, CYCLE_1,
    input  UPDATE_SETTINGS, REQ_RD_SEGMENT, REP_0, REP_1, PENDING, DROPPED, MODE_ERR
  );
  modport slave (
    input  SETTINGS_VALID, REQ_SEGMENT, REQ_REP, TRANSITION_MODE, TRANSITION_VALUE,
    input  SYS_TIME, GPIO_IN, CUR_SEGMENT, IDX_0, IDX_1, CYCLE_0, CYCLE_1,
    output UPDATE_SETTINGS, REQ_RD_SEGMENT, REP_0, REP_1, PENDING, DROPPED, MODE_ERR
  );
endinterface

// File: rtl/stm_transition_scheduler.sv
// stm_transition_scheduler: holds a segment-change request until its transition condition
//   is met, then pulses UPDATE_SETTINGS with stable REQ_RD_SEGMENT/REP_0/REP_1
//   CLK : system clock
//   RST : synchronous reset, active-high
//   bus : stm_transition_scheduler_if.slave (request in, status in, result out)
module stm_transition_scheduler
  import stm_sched_pkg::*;
#(
  parameter int TIME_W = 64,
  parameter int GPIO_N = 4
) (
  input logic CLK,
  input logic RST,
  stm_transition_scheduler_if.slave bus
);
  localparam int SEL_W = GPIO_N > 1 ? $clog2(GPIO_N) : 1;
  sched_state_t state, state_n;
  logic p_seg;
  logic [31:0] p_rep;
  transition_mode_t p_mode;
  logic [TIME_W-1:0] p_val;
  logic [GPIO_N-1:0] gpio_prev;
  logic [SEL_W-1:0] req_sel, sel;
  logic req_ok, accept, cond, fire;
  assign req_sel = bus.TRANSITION_VALUE[SEL_W-1:0];
  assign sel = p_val[SEL_W-1:0];
  always_comb begin
    req_ok = mode_defined(bus.TRANSITION_MODE) &&
             (bus.TRANSITION_MODE != MODE_GPIO || 32'(req_sel) < 32'(GPIO_N));
    accept = bus.SETTINGS_VALID && req_ok;
    cond = p_mode == TM_IMMEDIATE ? 1'b1 :
           p_mode == TM_SYNC_IDX  ? (bus.CUR_SEGMENT ? bus.IDX_1 == bus.CYCLE_1 : bus.IDX_0 == bus.CYCLE_0) :
           p_mode == TM_SYS_TIME  ? bus.SYS_TIME >= p_val :
                                    bus.GPIO_IN[sel] & ~gpio_prev[sel];
    // a request arriving in WAIT replaces the pending one, so the old condition is ignored
    fire = state == ST_WAIT && !accept && cond;
    state_n = accept ? ST_WAIT : fire ? ST_FIRE : state == ST_FIRE ? ST_IDLE : state;
  end
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else state <= state_n;
  end
  // edge history runs in every state so a level already high at latch time never fires
  always_ff @(posedge CLK) gpio_prev <= bus.GPIO_IN;
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_seg <= 1'b0;
      p_rep <= REP_INFINITE;
      p_mode <= TM_IMMEDIATE;
      p_val <= '0;
      bus.REQ_RD_SEGMENT <= 1'b0;
      bus.REP_0 <= REP_INFINITE;
      bus.REP_1 <= REP_INFINITE;
      bus.DROPPED <= 1'b0;
      bus.MODE_ERR <= 1'b0;
    end else begin
      bus.DROPPED <= accept && state == ST_WAIT;
      bus.MODE_ERR <= bus.SETTINGS_VALID && !req_ok;
      if (accept) begin
        p_seg <= bus.REQ_SEGMENT;
        p_rep <= bus.REQ_REP;
        p_mode <= transition_mode_t'(bus.TRANSITION_MODE);
        p_val <= bus.TRANSITION_VALUE;
      end
      if (fire) begin
        bus.REQ_RD_SEGMENT <= p_seg;
        if (p_seg) bus.REP_1 <= p_rep;
        else bus.REP_0 <= p_rep;
      end
    end
  end
  assign bus.UPDATE_SETTINGS = state == ST_FIRE;
  assign bus.PENDING = state == ST_WAIT;
endmodule

// File: tb/tb_stm_transition_scheduler.sv
// tb_stm_transition_scheduler: scoreboard bench for stm_transition_scheduler
module tb_stm_transition_scheduler;
  localparam logic [31:0] INF = 32'hFFFF_FFFF;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  stm_transition_scheduler_if #(.TIME_W(64), .GPIO_N(4)) bus();
  stm_transition_scheduler #(.TIME_W(64), .GPIO_N(4)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  typedef struct {
    int c;
    logic s;
    logic [31:0] r0;
    logic [31:0] r1;
  } upd_t;
  upd_t uq[$];
  int dq[$];
  int mq[$];
  int n_cmp = 0;
  int n_err = 0;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic issue(input logic s, input logic [31:0] r, input logic [2:0] m, input logic [63:0] v);
    bus.SETTINGS_VALID = 1'b1;
    bus.REQ_SEGMENT = s;
    bus.REQ_REP = r;
    bus.TRANSITION_MODE = m;
    bus.TRANSITION_VALUE = v;
    step();
    bus.SETTINGS_VALID = 1'b0;
  endtask
  task automatic exp_upd(input int c, input logic s, input logic [31:0] r0, input logic [31:0] r1);
    upd_t u;
    u.c = c;
    u.s = s;
    u.r0 = r0;
    u.r1 = r1;
    uq.push_back(u);
  endtask
  task automatic monitor();
    upd_t u;
    int c;
    forever begin
      @(negedge CLK);
      if (bus.UPDATE_SETTINGS) begin
        if (uq.size() == 0) chk("unexpected_update", 64'(bus.UPDATE_SETTINGS), 0);
        else begin
          u = uq.pop_front();
          chk("upd_cycle", 64'(cyc), 64'(u.c));
          chk("upd_seg", 64'(bus.REQ_RD_SEGMENT), 64'(u.s));
          chk("upd_rep0", 64'(bus.REP_0), 64'(u.r0));
          chk("upd_rep1", 64'(bus.REP_1), 64'(u.r1));
        end
      end
      if (bus.DROPPED) begin
        if (dq.size() == 0) chk("unexpected_dropped", 64'(bus.DROPPED), 0);
        else begin
          c = dq.pop_front();
          chk("dropped_cycle", 64'(cyc), 64'(c));
        end
      end
      if (bus.MODE_ERR) begin
        if (mq.size() == 0) chk("unexpected_mode_err", 64'(bus.MODE_ERR), 0);
        else begin
          c = mq.pop_front();
          chk("mode_err_cycle", 64'(cyc), 64'(c));
        end
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    bus.SETTINGS_VALID = 0;
    bus.REQ_SEGMENT = 0;
    bus.REQ_REP = 0;
    bus.TRANSITION_MODE = 0;
    bus.TRANSITION_VALUE = 0;
    bus.SYS_TIME = 0;
    bus.GPIO_IN = 0;
    bus.CUR_SEGMENT = 0;
    bus.IDX_0 = 0;
    bus.IDX_1 = 0;
    bus.CYCLE_0 = 16'd100;
    bus.CYCLE_1 = 16'd5;
    repeat (3) step();
    RST = 1'b0;
    chk("rst_rep0", 64'(bus.REP_0), 64'(INF));
    chk("rst_rep1", 64'(bus.REP_1), 64'(INF));
    chk("rst_update", 64'(bus.UPDATE_SETTINGS), 0);
    chk("rst_pending", 64'(bus.PENDING), 0);
    chk("rst_rd_seg", 64'(bus.REQ_RD_SEGMENT), 0);
    chk("rst_dropped", 64'(bus.DROPPED), 0);
    chk("rst_mode_err", 64'(bus.MODE_ERR), 0);
    fork
      monitor();
      begin
        exp_upd(cyc + 2, 1'b1, INF, 32'd5);
        issue(1'b1, 32'd5, 3'd0, 64'd0);
        chk("imm_pending", 64'(bus.PENDING), 1);
        repeat (4) step();
        bus.SYS_TIME = 64'd990;
        exp_upd(cyc + 11, 1'b0, 32'd7, 32'd5);
        issue(1'b0, 32'd7, 3'd2, 64'd1000);
        for (int i = 1; i <= 15; i++) begin
          if (i == 10) chk("time_pending_last", 64'(bus.PENDING), 1);
          bus.SYS_TIME = 64'd990 + 64'(i);
          step();
        end
        bus.SYS_TIME = 64'd500;
        exp_upd(cyc + 2, 1'b1, 32'd7, 32'd9);
        issue(1'b1, 32'd9, 3'd2, 64'd10);
        repeat (4) step();
        bus.CUR_SEGMENT = 1'b0;
        bus.CYCLE_0 = 16'd9;
        bus.IDX_0 = 16'd3;
        exp_upd(cyc + 7, 1'b1, 32'd7, 32'd100);
        issue(1'b1, 32'd100, 3'd1, 64'd0);
        for (int i = 1; i <= 10; i++) begin
          bus.IDX_0 = 16'd3 + 16'(i);
          step();
        end
        bus.IDX_0 = 16'd0;
        repeat (2) step();
        bus.GPIO_IN = 4'b0100;
        step();
        issue(1'b0, 32'd11, 3'd3, 64'd2);
        for (int i = 0; i < 6; i++) begin
          bus.GPIO_IN[1] = ~bus.GPIO_IN[1];
          step();
        end
        chk("gpio_high_still_pending", 64'(bus.PENDING), 1);
        bus.GPIO_IN = 4'b0000;
        step();
        exp_upd(cyc + 1, 1'b0, 32'd11, 32'd100);
        bus.GPIO_IN = 4'b0100;
        step();
        repeat (3) step();
        mq.push_back(cyc + 1);
        issue(1'b0, 32'd77, 3'd5, 64'd0);
        chk("mode_err_pending", 64'(bus.PENDING), 0);
        repeat (3) step();
        chk("mode_err_rep0", 64'(bus.REP_0), 64'd11);
        bus.SYS_TIME = 64'd500;
        issue(1'b0, 32'd21, 3'd2, 64'd5000);
        step();
        step();
        dq.push_back(cyc + 1);
        exp_upd(cyc + 2, 1'b1, 32'd11, 32'd33);
        issue(1'b1, 32'd33, 3'd0, 64'd0);
        chk("drop_pending", 64'(bus.PENDING), 1);
        repeat (4) step();
        issue(1'b0, 32'd44, 3'd2, 64'd5000);
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        bus.SYS_TIME = 64'd6000;
        repeat (8) step();
        chk("midrst_pending", 64'(bus.PENDING), 0);
        chk("midrst_rep0", 64'(bus.REP_0), 64'(INF));
        chk("midrst_rep1", 64'(bus.REP_1), 64'(INF));
        chk("midrst_rd_seg", 64'(bus.REQ_RD_SEGMENT), 0);
        exp_upd(cyc + 2, 1'b0, 32'd50, INF);
        issue(1'b0, 32'd50, 3'd0, 64'd0);
        step();
        exp_upd(cyc + 2, 1'b1, 32'd50, 32'd60);
        issue(1'b1, 32'd60, 3'd0, 64'd0);
        repeat (5) step();
      end
    join_any
    disable fork;
    chk("updates_outstanding", 64'(uq.size()), 0);
    chk("dropped_outstanding", 64'(dq.size()), 0);
    chk("mode_err_outstanding", 64'(mq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
